room_occupancy_ctrl: RTL and testbench
======================================

Name: room_occupancy_ctrl

Overview:
- Controls room lighting and access from two doors (A, B), each fitted with an outer and an inner beam sensor.
- A per-door direction FSM turns beam-break sequences into enter/exit events.
- A saturating occupancy counter tracks headcount and drives a delayed-off light, a capacity-full flag (door lock) and sticky error flags.
- Sits between the raw sensor inputs and the room actuators.

Parameters:
CW, 8, occupancy counter width
MAX_OCC, 50, capacity; full asserted when occupancy >= MAX_OCC (must be <= 2^CW-1)
OFF_DELAY, 16, cycles light stays on after occupancy reaches 0 (0 = immediate)
TIMEOUT, 1000, max consecutive cycles a door FSM may stay out of IDLE

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous reset, active high
a_out  in  1  door A outer beam broken (1 = blocked)
a_in  in  1  door A inner beam broken
b_out  in  1  door B outer beam broken
b_in  in  1  door B inner beam broken
enter_p  out  2  one-cycle enter pulse, bit0 = door A, bit1 = door B
exit_p  out  2  one-cycle exit pulse, bit0 = door A, bit1 = door B
occupancy  out  CW  current headcount
light  out  1  room light on
full  out  1  occupancy >= MAX_OCC
err  out  3  sticky: [0] underflow, [1] overflow, [2] door timeout

Behaviour:
- Sensor inputs are already synchronous to clk. No debounce is applied.
- Reset (sync, rst=1 at an edge):
  - Door FSMs go to IDLE; timeout counters cleared.
  - enter_p = exit_p = 0, occupancy = 0, light = 0, full = 0, err = 0.
  - Reset mid-traversal abandons the traversal with no pulse.
- Door FSM (one per door, identical). Notation: o = outer beam, i = inner beam; all transitions are on the sampled values.
  - IDLE: o&!i -> I1; !o&i -> O1; o&i or idle -> stay.
  - I1 (outer only): o&i -> I2; !o&!i -> IDLE (backed out); else stay.
  - I2 (both): !o&i -> I3; o&!i -> I1; else stay.
  - I3 (inner only): !o&!i -> IDLE and fire enter pulse; o&i -> I2; else stay.
  - O1 / O2 / O3 mirror I1..I3 with inner/outer swapped; O3 -> IDLE with both clear fires the exit pulse.
  - Pulse timing: the pulse is registered, high for exactly the one cycle following the completing edge.
  - Timeout: a per-door counter runs while the FSM is not IDLE and clears in IDLE. When it reaches TIMEOUT, the FSM is forced to IDLE with no pulse and err[2] is set.
- Occupancy:
  - Updated at the edge after the pulse cycle: delta = popcount(enter_p) - popcount(exit_p), range -2..+2.
  - Result below 0 clamps to 0 and sets err[0].
  - Result above 2^CW-1 clamps to 2^CW-1 and sets err[1].
  - Simultaneous enter on A and exit on B gives net 0, no error.
- full: registered from the next occupancy value, so it changes on the same edge as occupancy.
- light:
  - Rises on the same edge occupancy becomes nonzero.
  - When occupancy becomes 0, an off-timer loads OFF_DELAY; light falls exactly OFF_DELAY edges later.
  - Occupancy becoming nonzero during the countdown cancels the timer; light stays 1.
  - OFF_DELAY = 0 drops light on the same edge occupancy hits 0.
- err bits clear only on rst.

Test Plan:
- Door A sequence (a_out,a_in) = 10,11,01,00, one cycle each -> enter_p = 01 for one cycle after the 00 edge; occupancy = 1 on the next edge; light = 1 on that same edge.
- Door A sequence 10,11,10,00 (person turns back) -> no pulse; occupancy stays 0.
- Occupancy = 1, then door B exit sequence 01,11,10,00 -> exit_p = 10 pulse; occupancy = 0; light stays 1 for 16 cycles and is 0 on the 16th edge. A re-entry at cycle 8 keeps light = 1 continuously.
- Occupancy = 3, with A-enter and B-exit completing on the same edge -> enter_p = 01 and exit_p = 10 together; occupancy stays 3.
- Occupancy = 0, then an exit sequence on both doors simultaneously -> occupancy stays 0; err = 001.
- MAX_OCC = 2: drive 2 entries -> full = 1 with occupancy = 2. Holding a_out = 1 for 1000 cycles -> door A returns to IDLE and err[2] = 1. Asserting rst mid-sequence clears all outputs on the next edge.

Source files
------------

// File: rtl/room_occupancy_ctrl_if.sv
// Sensor-to-actuator bundle for the room controller; the slave side is the controller.
// Outputs carry registered results with no backpressure (sensor inputs are never stalled).
interface room_occupancy_ctrl_if #(
    parameter int CW = 8
);
    logic          a_out;
    logic          a_in;
    logic          b_out;
    logic          b_in;
    logic [1:0]    enter_p;
    logic [1:0]    exit_p;
    logic [CW-1:0] occupancy;
    logic          light;
    logic          full;
    logic [2:0]    err;

    modport master (
        output a_out, a_in, b_out, b_in,
        input  enter_p, exit_p, occupancy, light, full, err
    );

    modport slave (
        input  a_out, a_in, b_out, b_in,
        output enter_p, exit_p, occupancy, light, full, err
    );
endinterface

// File: rtl/room_occupancy_ctrl.sv
// Two-door beam-sequence decoder, saturating headcount, delayed-off light; pulse 1 cycle after
// the completing edge, occupancy/full/light 1 cycle after that; no backpressure (inputs always sampled).
module room_door_fsm #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic outer_i,
    input  logic inner_i,
    output logic enter_o,
    output logic exit_o,
    output logic timeout_o
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        I1   = 3'd1,
        I2   = 3'd2,
        I3   = 3'd3,
        O1   = 3'd4,
        O2   = 3'd5,
        O3   = 3'd6
    } door_state_e;

    door_state_e   state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          enter_q, enter_d;
    logic          exit_q, exit_d;
    logic          tmo_hit;
    logic          o, i;

    assign o = outer_i;
    assign i = inner_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tmo_q   <= '0;
            enter_q <= 1'b0;
            exit_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            enter_q <= enter_d;
            exit_q  <= exit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        enter_d = 1'b0;
        exit_d  = 1'b0;
        tmo_hit = (state_q != IDLE) && (tmo_q == TW'(TIMEOUT - 1));
        tmo_d   = (state_q == IDLE) ? '0 : tmo_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (o && !i)      state_d = I1;
                else if (!o && i) state_d = O1;
            end
            I1: begin
                if (o && i)        state_d = I2;
                else if (!o && !i) state_d = IDLE;
            end
            I2: begin
                if (!o && i)      state_d = I3;
                else if (o && !i) state_d = I1;
            end
            I3: begin
                if (!o && !i) begin
                    state_d = IDLE;
                    enter_d = 1'b1;
                end else if (o && i) begin
                    state_d = I2;
                end
            end
            O1: begin
                if (o && i)        state_d = O2;
                else if (!o && !i) state_d = IDLE;
            end
            O2: begin
                if (o && !i)      state_d = O3;
                else if (!o && i) state_d = O1;
            end
            O3: begin
                if (!o && !i) begin
                    state_d = IDLE;
                    exit_d  = 1'b1;
                end else if (o && i) begin
                    state_d = O2;
                end
            end
            default: state_d = IDLE;
        endcase

        // A stuck traversal is abandoned silently after TIMEOUT cycles away from IDLE.
        if (tmo_hit) begin
            state_d = IDLE;
            enter_d = 1'b0;
            exit_d  = 1'b0;
            tmo_d   = '0;
        end
    end

    assign enter_o   = enter_q;
    assign exit_o    = exit_q;
    assign timeout_o = tmo_hit;
endmodule

module room_occupancy_ctrl #(
    parameter int CW        = 8,
    parameter int MAX_OCC   = 50,
    parameter int OFF_DELAY = 16,
    parameter int TIMEOUT   = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    room_occupancy_ctrl_if.slave  room_io
);
    localparam int DW = (OFF_DELAY > 0) ? $clog2(OFF_DELAY + 1) : 1;
    localparam logic [CW-1:0] OCC_MAX = '1;

    logic [1:0]    enter_w, exit_w, tmo_w;
    logic [CW-1:0] occ_q, occ_d;
    logic          full_q, full_d;
    logic          light_q, light_d;
    logic [DW-1:0] off_q, off_d;
    logic [2:0]    err_q, err_d;
    logic [1:0]    n_in, n_out;
    logic [CW+1:0] inc_sum, net_sum;
    logic          unf, ovf;

    room_door_fsm #(.TIMEOUT(TIMEOUT)) u_door_a (
        .clk       (clk),
        .rst       (rst),
        .outer_i   (room_io.a_out),
        .inner_i   (room_io.a_in),
        .enter_o   (enter_w[0]),
        .exit_o    (exit_w[0]),
        .timeout_o (tmo_w[0])
    );

    room_door_fsm #(.TIMEOUT(TIMEOUT)) u_door_b (
        .clk       (clk),
        .rst       (rst),
        .outer_i   (room_io.b_out),
        .inner_i   (room_io.b_in),
        .enter_o   (enter_w[1]),
        .exit_o    (exit_w[1]),
        .timeout_o (tmo_w[1])
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q   <= '0;
            full_q  <= 1'b0;
            light_q <= 1'b0;
            off_q   <= '0;
            err_q   <= '0;
        end else begin
            occ_q   <= occ_d;
            full_q  <= full_d;
            light_q <= light_d;
            off_q   <= off_d;
            err_q   <= err_d;
        end
    end

    // Headcount works on the registered pulses, so it trails them by one edge.
    always_comb begin
        n_in    = {1'b0, enter_w[0]} + {1'b0, enter_w[1]};
        n_out   = {1'b0, exit_w[0]} + {1'b0, exit_w[1]};
        inc_sum = {2'b00, occ_q} + {{CW{1'b0}}, n_in};
        net_sum = '0;
        unf     = 1'b0;
        ovf     = 1'b0;
        occ_d   = occ_q;
        if (inc_sum < {{CW{1'b0}}, n_out}) begin
            unf   = 1'b1;
            occ_d = '0;
        end else begin
            net_sum = inc_sum - {{CW{1'b0}}, n_out};
            if (net_sum > {2'b00, OCC_MAX}) begin
                ovf   = 1'b1;
                occ_d = OCC_MAX;
            end else begin
                occ_d = net_sum[CW-1:0];
            end
        end
        full_d = (occ_d >= CW'(MAX_OCC));
        err_d  = err_q | {|tmo_w, ovf, unf};
    end

    always_comb begin
        light_d = light_q;
        off_d   = off_q;
        if (occ_d != '0) begin
            light_d = 1'b1;
            off_d   = '0;
        end else if (occ_q != '0) begin
            if (OFF_DELAY == 0) light_d = 1'b0;
            else                off_d   = DW'(OFF_DELAY);
        end else if (off_q != '0) begin
            off_d = off_q - 1'b1;
            if (off_q == DW'(1)) light_d = 1'b0;
        end
    end

    assign room_io.enter_p   = enter_w;
    assign room_io.exit_p    = exit_w;
    assign room_io.occupancy = occ_q;
    assign room_io.light     = light_q;
    assign room_io.full      = full_q;
    assign room_io.err       = err_q;
endmodule

// File: tb/tb_room_occupancy_ctrl.sv
// Directed vector table plus hand-written multi-cycle sequences for room_occupancy_ctrl (MAX_OCC=2).
module tb_room_occupancy_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    room_occupancy_ctrl_if #(.CW(8)) rio ();

    room_occupancy_ctrl #(
        .CW(8), .MAX_OCC(2), .OFF_DELAY(16), .TIMEOUT(1000)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .room_io (rio)
    );

    typedef struct {
        logic [3:0] sens;   // {a_out, a_in, b_out, b_in}
        logic [1:0] en;
        logic [1:0] ex;
        logic [7:0] occ;
        logic       light;
        logic       full;
        logic [2:0] err;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic [3:0] s, input logic [1:0] en, input logic [1:0] ex,
                                input logic [7:0] occ, input logic light, input logic full,
                                input logic [2:0] err);
        vec_t v;
        v.sens = s; v.en = en; v.ex = ex; v.occ = occ;
        v.light = light; v.full = full; v.err = err;
        return v;
    endfunction

    task automatic tick(input logic [3:0] s);
        rio.a_out = s[3];
        rio.a_in  = s[2];
        rio.b_out = s[1];
        rio.b_in  = s[0];
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [1:0] en, input logic [1:0] ex,
                           input logic [7:0] occ, input logic light, input logic full,
                           input logic [2:0] err);
        chk({nm, ".enter_p"},   32'(rio.enter_p),   32'(en));
        chk({nm, ".exit_p"},    32'(rio.exit_p),    32'(ex));
        chk({nm, ".occupancy"}, 32'(rio.occupancy), 32'(occ));
        chk({nm, ".light"},     32'(rio.light),     32'(light));
        chk({nm, ".full"},      32'(rio.full),      32'(full));
        chk({nm, ".err"},       32'(rio.err),       32'(err));
    endtask

    task automatic enter_a();
        tick(4'b1000); tick(4'b1100); tick(4'b0100); tick(4'b0000);
    endtask

    task automatic exit_b();
        tick(4'b0001); tick(4'b0011); tick(4'b0010); tick(4'b0000);
    endtask

    initial begin
        rio.a_out = 1'b0; rio.a_in = 1'b0; rio.b_out = 1'b0; rio.b_in = 1'b0;

        // sens, enter, exit, occ, light, full, err (values after the edge)
        vt.push_back(mk(4'b1000, 2'b00, 2'b00, 8'd0, 1'b0, 1'b0, 3'b000));
        vt.push_back(mk(4'b1100, 2'b00, 2'b00, 8'd0, 1'b0, 1'b0, 3'b000));
        vt.push_back(mk(4'b0100, 2'b00, 2'b00, 8'd0, 1'b0, 1'b0, 3'b000));
        vt.push_back(mk(4'b0000, 2'b01, 2'b00, 8'd0, 1'b0, 1'b0, 3'b000));
        vt.push_back(mk(4'b0000, 2'b00, 2'b00, 8'd1, 1'b1, 1'b0, 3'b000));
        vt.push_back(mk(4'b1000, 2'b00, 2'b00, 8'd1, 1'b1, 1'b0, 3'b000));
        vt.push_back(mk(4'b1100, 2'b00, 2'b00, 8'd1, 1'b1, 1'b0, 3'b000));
        vt.push_back(mk(4'b1000, 2'b00, 2'b00, 8'd1, 1'b1, 1'b0, 3'b000));
        vt.push_back(mk(4'b0000, 2'b00, 2'b00, 8'd1, 1'b1, 1'b0, 3'b000));
        vt.push_back(mk(4'b0000, 2'b00, 2'b00, 8'd1, 1'b1, 1'b0, 3'b000));
        vt.push_back(mk(4'b1000, 2'b00, 2'b00, 8'd1, 1'b1, 1'b0, 3'b000));
        vt.push_back(mk(4'b1100, 2'b00, 2'b00, 8'd1, 1'b1, 1'b0, 3'b000));
        vt.push_back(mk(4'b0100, 2'b00, 2'b00, 8'd1, 1'b1, 1'b0, 3'b000));
        vt.push_back(mk(4'b0000, 2'b01, 2'b00, 8'd1, 1'b1, 1'b0, 3'b000));
        vt.push_back(mk(4'b0000, 2'b00, 2'b00, 8'd2, 1'b1, 1'b1, 3'b000));
        vt.push_back(mk(4'b0010, 2'b00, 2'b00, 8'd2, 1'b1, 1'b1, 3'b000));
        vt.push_back(mk(4'b0011, 2'b00, 2'b00, 8'd2, 1'b1, 1'b1, 3'b000));
        vt.push_back(mk(4'b0001, 2'b00, 2'b00, 8'd2, 1'b1, 1'b1, 3'b000));
        vt.push_back(mk(4'b0000, 2'b10, 2'b00, 8'd2, 1'b1, 1'b1, 3'b000));
        vt.push_back(mk(4'b0000, 2'b00, 2'b00, 8'd3, 1'b1, 1'b1, 3'b000));
        vt.push_back(mk(4'b1001, 2'b00, 2'b00, 8'd3, 1'b1, 1'b1, 3'b000));
        vt.push_back(mk(4'b1111, 2'b00, 2'b00, 8'd3, 1'b1, 1'b1, 3'b000));
        vt.push_back(mk(4'b0110, 2'b00, 2'b00, 8'd3, 1'b1, 1'b1, 3'b000));
        vt.push_back(mk(4'b0000, 2'b01, 2'b10, 8'd3, 1'b1, 1'b1, 3'b000));
        vt.push_back(mk(4'b0000, 2'b00, 2'b00, 8'd3, 1'b1, 1'b1, 3'b000));
        vt.push_back(mk(4'b0101, 2'b00, 2'b00, 8'd3, 1'b1, 1'b1, 3'b000));
        vt.push_back(mk(4'b1111, 2'b00, 2'b00, 8'd3, 1'b1, 1'b1, 3'b000));
        vt.push_back(mk(4'b1010, 2'b00, 2'b00, 8'd3, 1'b1, 1'b1, 3'b000));
        vt.push_back(mk(4'b0000, 2'b00, 2'b11, 8'd3, 1'b1, 1'b1, 3'b000));
        vt.push_back(mk(4'b0000, 2'b00, 2'b00, 8'd1, 1'b1, 1'b0, 3'b000));
        vt.push_back(mk(4'b0001, 2'b00, 2'b00, 8'd1, 1'b1, 1'b0, 3'b000));
        vt.push_back(mk(4'b0011, 2'b00, 2'b00, 8'd1, 1'b1, 1'b0, 3'b000));
        vt.push_back(mk(4'b0010, 2'b00, 2'b00, 8'd1, 1'b1, 1'b0, 3'b000));
        vt.push_back(mk(4'b0000, 2'b00, 2'b10, 8'd1, 1'b1, 1'b0, 3'b000));
        vt.push_back(mk(4'b0000, 2'b00, 2'b00, 8'd0, 1'b1, 1'b0, 3'b000));

        rst = 1'b1;
        tick(4'b0000);
        chk_all("reset", 2'b00, 2'b00, 8'd0, 1'b0, 1'b0, 3'b000);
        rst = 1'b0;

        for (int k = 0; k < vt.size(); k++) begin
            tick(vt[k].sens);
            chk_all($sformatf("vec%0d", k), vt[k].en, vt[k].ex, vt[k].occ,
                    vt[k].light, vt[k].full, vt[k].err);
        end

        // Occupancy hit 0 on the last vector edge: light holds 15 more edges, drops on the 16th.
        for (int k = 1; k <= 16; k++) begin
            tick(4'b0000);
            chk($sformatf("offdelay_edge%0d", k), 32'(rio.light), (k < 16) ? 32'd1 : 32'd0);
        end

        // Re-entry during the countdown keeps the light on without a gap.
        enter_a();
        tick(4'b0000);
        chk("reentry.setup_occ", 32'(rio.occupancy), 32'd1);
        exit_b();
        tick(4'b0000);
        chk("reentry.zero_occ", 32'(rio.occupancy), 32'd0);
        for (int j = 0; j < 30; j++) begin
            logic [3:0] s;
            case (j)
                3:       s = 4'b1000;
                4:       s = 4'b1100;
                5:       s = 4'b0100;
                default: s = 4'b0000;
            endcase
            tick(s);
            chk($sformatf("reentry.light%0d", j), 32'(rio.light), 32'd1);
        end
        chk("reentry.final_occ", 32'(rio.occupancy), 32'd1);

        // Underflow: both doors report an exit with only one person inside after the first exit.
        exit_b();
        tick(4'b0000);
        chk("unf.setup_occ", 32'(rio.occupancy), 32'd0);
        tick(4'b0101); tick(4'b1111); tick(4'b1010); tick(4'b0000);
        chk("unf.exit_pulse", 32'(rio.exit_p), 32'b11);
        tick(4'b0000);
        chk("unf.occ", 32'(rio.occupancy), 32'd0);
        chk("unf.err", 32'(rio.err), 32'b001);

        // Door A outer beam held: timeout fires near 1000 cycles with no pulse.
        for (int k = 0; k < 990; k++) tick(4'b1000);
        chk("tmo.err_before", 32'(rio.err), 32'b001);
        for (int k = 0; k < 20; k++) tick(4'b1000);
        chk("tmo.err_after", 32'(rio.err), 32'b101);
        chk("tmo.enter", 32'(rio.enter_p), 32'b00);
        tick(4'b0000); tick(4'b0000); tick(4'b0000);
        chk("tmo.occ", 32'(rio.occupancy), 32'd0);

        // Reset mid-traversal clears everything and the traversal never completes.
        enter_a();
        tick(4'b0000);
        chk("rstmid.setup_occ", 32'(rio.occupancy), 32'd1);
        tick(4'b1000); tick(4'b1100);
        rst = 1'b1;
        tick(4'b0100);
        chk_all("rstmid", 2'b00, 2'b00, 8'd0, 1'b0, 1'b0, 3'b000);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(4'b0000);
            chk($sformatf("rstmid.nopulse%0d", k), 32'({rio.enter_p, rio.exit_p}), 32'd0);
        end
        chk("rstmid.occ", 32'(rio.occupancy), 32'd0);

        // Saturation: 2 entries per round through both doors.
        for (int r = 0; r < 127; r++) begin
            tick(4'b1010); tick(4'b1111); tick(4'b0101); tick(4'b0000);
        end
        tick(4'b0000);
        chk_all("ovf.pre", 2'b00, 2'b00, 8'd254, 1'b1, 1'b1, 3'b000);
        tick(4'b1010); tick(4'b1111); tick(4'b0101); tick(4'b0000);
        tick(4'b0000);
        tick(4'b0000);
        chk_all("ovf.post", 2'b00, 2'b00, 8'd255, 1'b1, 1'b1, 3'b010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
